// File: rtl/vend_ctrl_multi_if.sv
// rtl/vend_ctrl_multi_if.sv - front-end/driver signal bundle for the multi-product vending controller
interface vend_ctrl_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8
);
    localparam int ID_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    // Coin acceptor / keypad / service side
    logic [1:0]           coin;
    logic                 sel_valid;
    logic [ID_W-1:0]      sel_id;
    logic                 cancel;
    logic                 restock_valid;
    logic [ID_W-1:0]      restock_id;
    logic                 change_rdy;

    // Dispenser / hopper / status side
    logic                 vend;
    logic [ID_W-1:0]      vend_id;
    logic                 change_pulse;
    logic                 coin_reject;
    logic                 sel_err;
    logic [CREDIT_W-1:0]  credit;
    logic                 busy;
    logic [NUM_ITEMS-1:0] sold_out;

    // Front-end / environment view
    modport master (
        output coin, sel_valid, sel_id, cancel, restock_valid, restock_id, change_rdy,
        input  vend, vend_id, change_pulse, coin_reject, sel_err, credit, busy, sold_out
    );

    // Controller view
    modport slave (
        input  coin, sel_valid, sel_id, cancel, restock_valid, restock_id, change_rdy,
        output vend, vend_id, change_pulse, coin_reject, sel_err, credit, busy, sold_out
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - parametrised multi-product vending controller with stock, refund and change
module vend_ctrl_multi #(
    parameter int                            NUM_ITEMS   = 4,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES      = {8'd50, 8'd30, 8'd20, 8'd15},
    parameter int                            COIN1_VAL   = 5,
    parameter int                            COIN2_VAL   = 10,
    parameter int                            COIN3_VAL   = 25,
    parameter int                            MAX_CREDIT  = 100,
    parameter int                            CHANGE_UNIT = 5,
    parameter int                            STOCK_MAX   = 3
) (
    input  logic              clk,
    input  logic              rst,
    vend_ctrl_multi_if.slave  bus
);
    localparam int ID_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int STK_W = $clog2(STOCK_MAX + 1);

    localparam logic [CREDIT_W-1:0] UNIT_C = CREDIT_W'(CHANGE_UNIT);
    localparam logic [CREDIT_W:0]   MAX_C  = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STK_W-1:0]    FULL_S = STK_W'(STOCK_MAX);
    localparam logic [STK_W-1:0]    ONE_S  = STK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [ID_W-1:0]     vend_id_q, vend_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;
    logic [STK_W-1:0]    stock_q [NUM_ITEMS];
    logic                dec_en;

    logic [CREDIT_W-1:0] price_w [NUM_ITEMS];
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_in_range;
    logic [ID_W-1:0]     sel_idx;
    logic                sel_ok;
    logic                coin_present;

    // Unpack the flat price vector into one entry per slot
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
        assign price_w[g] = PRICES[g*CREDIT_W +: CREDIT_W];
    end

    // Slot ids beyond NUM_ITEMS only exist when NUM_ITEMS is not a power of two
    if (NUM_ITEMS < (1 << ID_W)) begin : g_range_chk
        assign sel_in_range = ({1'b0, bus.sel_id} < (ID_W+1)'(NUM_ITEMS));
    end else begin : g_range_all
        assign sel_in_range = 1'b1;
    end

    // Out-of-range ids are steered to slot 0 so the array lookups stay in bounds
    assign sel_idx      = sel_in_range ? bus.sel_id : '0;
    assign coin_present = (bus.coin != 2'b00);

    // Decode the coin code into its credit value
    always_comb begin
        coin_val = '0;
        case (bus.coin)
            2'b01:   coin_val = CREDIT_W'(COIN1_VAL);
            2'b10:   coin_val = CREDIT_W'(COIN2_VAL);
            2'b11:   coin_val = CREDIT_W'(COIN3_VAL);
            default: coin_val = '0;
        endcase
    end

    // One extra bit so a near-ceiling credit plus a coin cannot wrap before the ceiling test
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

    assign sel_ok = bus.sel_valid && sel_in_range &&
                    (stock_q[sel_idx] != '0) &&
                    (credit_q >= price_w[sel_idx]);

    // State, credit and registered pulse flags; reset aborts any vend/refund and drops credit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            vend_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    // Per-slot stock; a restock of a slot overrides a same-cycle vend decrement of it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= FULL_S;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (bus.restock_valid && (bus.restock_id == ID_W'(i))) begin
                    stock_q[i] <= FULL_S;
                end else if (dec_en && (vend_id_q == ID_W'(i)) && (stock_q[i] != '0)) begin
                    stock_q[i] <= stock_q[i] - ONE_S;
                end
            end
        end
    end

    // Next-state, credit arithmetic and pulse requests; priority cancel > select > coin
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        dec_en        = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel && (credit_q != '0)) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_present;
                end else if (sel_ok) begin
                    state_d       = S_VEND;
                    vend_id_d     = sel_idx;
                    coin_reject_d = coin_present;
                end else begin
                    sel_err_d = bus.sel_valid;
                    if (coin_present) begin
                        if (coin_sum <= MAX_C) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    state_d = (credit_d != '0) ? S_CREDIT : S_IDLE;
                end
            end

            S_VEND: begin
                // Selection already proved credit >= price, so this cannot underflow
                dec_en        = 1'b1;
                credit_d      = credit_q - price_w[vend_id_q];
                state_d       = (credit_d != '0) ? S_CHANGE : S_IDLE;
                coin_reject_d = coin_present;
            end

            S_CHANGE: begin
                coin_reject_d = coin_present;
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else if (bus.change_rdy) begin
                    credit_d = (credit_q > UNIT_C) ? (credit_q - UNIT_C) : '0;
                    if (credit_d == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    // Moore outputs; change_pulse is the hopper handshake gated by the CHANGE state
    assign bus.vend         = (state_q == S_VEND);
    assign bus.vend_id      = vend_id_q;
    assign bus.change_pulse = (state_q == S_CHANGE) && bus.change_rdy && (credit_q != '0);
    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_err      = sel_err_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = (state_q == S_VEND) || (state_q == S_CHANGE);

    // Sold-out flags straight from the stock counters
    always_comb begin
        bus.sold_out = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            bus.sold_out[i] = (stock_q[i] == '0);
        end
    end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - table-driven self-checking bench for vend_ctrl_multi
module tb_vend_ctrl_multi;
    localparam int C5  = 1;
    localparam int C10 = 2;
    localparam int C25 = 3;

    logic clk;
    logic rst;

    vend_ctrl_multi_if #(.NUM_ITEMS(4), .CREDIT_W(8)) bus ();

    vend_ctrl_multi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [1:0] coin;
        logic       sv;
        logic [1:0] sid;
        logic       can;
        logic       rv;
        logic [1:0] rid;
        logic       rdy;
        logic       e_vend;
        logic [1:0] e_vid;
        logic       e_chg;
        logic       e_crej;
        logic       e_serr;
        int         e_credit;
        logic       e_busy;
        logic [3:0] e_so;
    } vec_t;

    vec_t tbl[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic v(input int rstn, input int coin, input int sv, input int sid,
                     input int can, input int rv, input int rid, input int rdy,
                     input int e_vend, input int e_vid, input int e_chg, input int e_crej,
                     input int e_serr, input int e_credit, input int e_busy, input int e_so);
        vec_t t;
        t.rstn = (rstn != 0);   t.coin = 2'(coin);   t.sv = (sv != 0);   t.sid = 2'(sid);
        t.can = (can != 0);     t.rv = (rv != 0);    t.rid = 2'(rid);    t.rdy = (rdy != 0);
        t.e_vend = (e_vend != 0); t.e_vid = 2'(e_vid); t.e_chg = (e_chg != 0);
        t.e_crej = (e_crej != 0); t.e_serr = (e_serr != 0); t.e_credit = e_credit;
        t.e_busy = (e_busy != 0); t.e_so = 4'(e_so);
        tbl.push_back(t);
    endtask

    task automatic drive(input logic rstn, input logic [1:0] coin, input logic sv, input logic [1:0] sid,
                         input logic can, input logic rv, input logic [1:0] rid, input logic rdy);
        rst = rstn; bus.coin = coin; bus.sel_valid = sv; bus.sel_id = sid;
        bus.cancel = can; bus.restock_valid = rv; bus.restock_id = rid; bus.change_rdy = rdy;
    endtask

    // Three exact-credit (10+5) vends of item0; so_during is the sold-out pattern seen meanwhile
    task automatic three_vends_item0(input int so_during);
        for (int k = 0; k < 3; k++) begin
            v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, so_during);
            v(1, C5,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0, so_during);
            v(1, 0,   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15, 0, so_during);
            v(1, 0,   0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 15, 1, so_during);
        end
    endtask

    initial begin
        int pat [6];
        int pulses;
        int k;

        drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);

        // 1: two 10s, buy item0 (15), one change token
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0, 0);
        v(1, 0,   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 20, 0, 0);
        v(1, 0,   0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 20, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0,  5, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);

        // 3: fill to the ceiling, overflow coin rejected, buy item3 (50), ten tokens back
        for (int i = 0; i < 4; i++)
            v(1, C25, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 25*i, 0, 0);
        v(1, C5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 100, 0, 0);
        v(1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 100, 0, 0);
        v(1, 0,  1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 100, 0, 0);
        v(1, 0,  0, 0, 0, 0, 0, 1,  1, 3, 0, 0, 0, 100, 1, 0);
        for (int i = 0; i < 10; i++)
            v(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 50 - 5*i, 1, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);

        // 4: refill slot0, empty it with three vends, refused select, restock, select works
        v(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        three_vends_item0(0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
        v(1, C5,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0, 1);
        v(1, 0,   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15, 0, 1);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 15, 0, 1);
        v(1, 0,   0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 15, 0, 1);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15, 0, 0);
        v(1, 0,   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15, 0, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 15, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);

        // 5: coin with a valid select is rejected; coin during CHANGE rejected, credit held
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0, 0);
        v(1, C10, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 20, 0, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0, 20, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        v(1, C25, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        v(1, 0,   0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 25, 0, 0);
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 25, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 25, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 25, 1, 0);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 20, 1, 0);

        // 6: reset mid-CHANGE with credit 15, then prove stock is back to three
        v(0, 0,   0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 0, 0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0);
        three_vends_item0(0);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
        v(1, C10, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);
        v(1, C5,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 10, 0, 1);
        v(1, 0,   1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 15, 0, 1);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 15, 0, 1);
        v(1, 0,   0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 15, 0, 1);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 15, 1, 1);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 10, 1, 1);
        v(1, 0,   0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0,  5, 1, 1);
        v(1, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_vend", int'(bus.vend), 0);
        chk("rst_vend_id", int'(bus.vend_id), 0);
        chk("rst_change", int'(bus.change_pulse), 0);
        chk("rst_coin_reject", int'(bus.coin_reject), 0);
        chk("rst_sel_err", int'(bus.sel_err), 0);
        chk("rst_sold_out", int'(bus.sold_out), 0);

        // Table: inputs applied for one cycle, outputs sampled mid-cycle before the edge consumes them
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rstn, tbl[i].coin, tbl[i].sv, tbl[i].sid,
                  tbl[i].can, tbl[i].rv, tbl[i].rid, tbl[i].rdy);
            #1;
            chk($sformatf("v%0d_credit", i), int'(bus.credit), tbl[i].e_credit);
            chk($sformatf("v%0d_vend", i), int'(bus.vend), int'(tbl[i].e_vend));
            if (tbl[i].e_vend)
                chk($sformatf("v%0d_vend_id", i), int'(bus.vend_id), int'(tbl[i].e_vid));
            chk($sformatf("v%0d_change", i), int'(bus.change_pulse), int'(tbl[i].e_chg));
            chk($sformatf("v%0d_coin_reject", i), int'(bus.coin_reject), int'(tbl[i].e_crej));
            chk($sformatf("v%0d_sel_err", i), int'(bus.sel_err), int'(tbl[i].e_serr));
            chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(tbl[i].e_busy));
            chk($sformatf("v%0d_sold_out", i), int'(bus.sold_out), int'(tbl[i].e_so));
        end

        // 2: 25 in, item2 (30) refused, then cancel with a stalling hopper
        @(negedge clk); drive(1'b1, 2'(C25), 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk); drive(1'b1, 2'b00, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk); drive(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t2_sel_err", int'(bus.sel_err), 1);
        chk("t2_credit_kept", int'(bus.credit), 25);
        @(negedge clk); #1;
        chk("t2_sel_err_one_cycle", int'(bus.sel_err), 0);
        @(negedge clk); drive(1'b1, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);

        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 1; pat[5] = 1;
        pulses = 0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, (k < 6) ? pat[k][0] : 1'b1);
            #1;
            if (!bus.busy) break;
            if (bus.change_pulse) pulses++;
        end
        chk("t2_pulses", pulses, 5);
        chk("t2_done_cycle", k, 6);
        chk("t2_credit_zero", int'(bus.credit), 0);
        chk("t2_busy_low", int'(bus.busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
